// File: rtl/hough_out_capture.sv
// Capture stage behind the Hough accumulator: turns a Pixel/Frame/Line stream into
// (x, y, data) records, measures frame size, counts frames and flags ragged lines/overflow.
module hough_out_capture #(
  parameter int unsigned PIXEL_W        = 11,
  parameter int unsigned COORD_W        = 8,
  parameter int unsigned CAPTURE_FRAMES = 2,
  parameter int unsigned FCNT_W         = 8
) (
  input  logic               Clk,
  input  logic               nReset,
  input  logic               Arm,
  input  logic [PIXEL_W-1:0] PixelIn,
  input  logic               PixelEn,
  input  logic               FrameIn,
  input  logic               LineIn,
  output logic [PIXEL_W-1:0] PixelOut,
  output logic [COORD_W-1:0] XOut,
  output logic [COORD_W-1:0] YOut,
  output logic               ValidOut,
  output logic               FrameStart,
  output logic               FrameDone,
  output logic [COORD_W-1:0] WidthOut,
  output logic [COORD_W-1:0] HeightOut,
  output logic [FCNT_W-1:0]  FrameCount,
  output logic               LineErr,
  output logic               Overflow,
  output logic               Busy,
  output logic               Done
);

  typedef enum logic [1:0] {ARMED, CAPTURE, DONE} state_e;

  localparam logic [COORD_W-1:0] CMAX   = '1;
  // Separate frame counter so DONE is reached even if FrameCount wraps.
  localparam int unsigned        DCNT_W = $clog2(CAPTURE_FRAMES + 1);
  localparam logic [DCNT_W-1:0]  CF     = DCNT_W'(CAPTURE_FRAMES);

  state_e state_q, state_d;

  logic [PIXEL_W-1:0] pix_q, pix_d;
  logic [COORD_W-1:0] xo_q, xo_d, yo_q, yo_d;
  logic               valid_q, valid_d, fstart_q, fstart_d, fdone_q, fdone_d;
  logic [COORD_W-1:0] width_q, width_d, height_q, height_d;
  logic [FCNT_W-1:0]  fcount_q, fcount_d;
  logic               lineerr_q, lineerr_d, ovf_q, ovf_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d, refw_q, refw_d;
  logic               refok_q, refok_d;
  logic [DCNT_W-1:0]  frames_q, frames_d;

  logic [COORD_W-1:0] line_len;
  logic               last_frame;

  assign line_len   = (x_q == CMAX) ? CMAX : x_q + COORD_W'(1);
  assign last_frame = (frames_q + DCNT_W'(1)) == CF;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) state_q <= ARMED;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (Arm) begin
      state_d = ARMED;
    end else if (PixelEn && FrameIn) begin
      case (state_q)
        ARMED:   state_d = CAPTURE;
        CAPTURE: if (last_frame) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    pix_d     = pix_q;
    xo_d      = xo_q;
    yo_d      = yo_q;
    valid_d   = 1'b0;
    fstart_d  = 1'b0;
    fdone_d   = 1'b0;
    width_d   = width_q;
    height_d  = height_q;
    fcount_d  = fcount_q;
    lineerr_d = lineerr_q;
    ovf_d     = ovf_q;
    x_d       = x_q;
    y_d       = y_q;
    refw_d    = refw_q;
    refok_d   = refok_q;
    frames_d  = frames_q;
    if (Arm) begin
      x_d       = '0;
      y_d       = '0;
      width_d   = '0;
      height_d  = '0;
      fcount_d  = '0;
      lineerr_d = 1'b0;
      ovf_d     = 1'b0;
      refok_d   = 1'b0;
      frames_d  = '0;
    end else if (PixelEn) begin
      case (state_q)
        ARMED: begin
          if (FrameIn) begin
            x_d      = '0;
            y_d      = '0;
            refok_d  = 1'b0;
            fstart_d = 1'b1;
            valid_d  = 1'b1;
          end
        end
        CAPTURE: begin
          // FrameIn closes the current line exactly like LineIn does.
          if (FrameIn || LineIn) begin
            if (refok_q && (line_len != refw_q)) lineerr_d = 1'b1;
            if (!refok_q) begin
              refw_d  = line_len;
              refok_d = 1'b1;
            end
          end
          if (FrameIn) begin
            fdone_d  = 1'b1;
            width_d  = refok_q ? refw_q : line_len;
            height_d = (y_q == CMAX) ? CMAX : y_q + COORD_W'(1);
            fcount_d = fcount_q + FCNT_W'(1);
            frames_d = frames_q + DCNT_W'(1);
            if (!last_frame) begin
              x_d      = '0;
              y_d      = '0;
              refok_d  = 1'b0;
              fstart_d = 1'b1;
              valid_d  = 1'b1;
            end
          end else if (LineIn) begin
            x_d = '0;
            if (y_q == CMAX) ovf_d = 1'b1;
            else             y_d   = y_q + COORD_W'(1);
            valid_d = 1'b1;
          end else begin
            if (x_q == CMAX) ovf_d = 1'b1;
            else             x_d   = x_q + COORD_W'(1);
            valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (valid_d) begin
      pix_d = PixelIn;
      xo_d  = x_d;
      yo_d  = y_d;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      pix_q     <= '0;
      xo_q      <= '0;
      yo_q      <= '0;
      valid_q   <= 1'b0;
      fstart_q  <= 1'b0;
      fdone_q   <= 1'b0;
      width_q   <= '0;
      height_q  <= '0;
      fcount_q  <= '0;
      lineerr_q <= 1'b0;
      ovf_q     <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      refw_q    <= '0;
      refok_q   <= 1'b0;
      frames_q  <= '0;
    end else begin
      pix_q     <= pix_d;
      xo_q      <= xo_d;
      yo_q      <= yo_d;
      valid_q   <= valid_d;
      fstart_q  <= fstart_d;
      fdone_q   <= fdone_d;
      width_q   <= width_d;
      height_q  <= height_d;
      fcount_q  <= fcount_d;
      lineerr_q <= lineerr_d;
      ovf_q     <= ovf_d;
      x_q       <= x_d;
      y_q       <= y_d;
      refw_q    <= refw_d;
      refok_q   <= refok_d;
      frames_q  <= frames_d;
    end
  end

  assign PixelOut   = pix_q;
  assign XOut       = xo_q;
  assign YOut       = yo_q;
  assign ValidOut   = valid_q;
  assign FrameStart = fstart_q;
  assign FrameDone  = fdone_q;
  assign WidthOut   = width_q;
  assign HeightOut  = height_q;
  assign FrameCount = fcount_q;
  assign LineErr    = lineerr_q;
  assign Overflow   = ovf_q;
  assign Busy       = (state_q == CAPTURE);
  assign Done       = (state_q == DONE);

endmodule

// File: tb/tb_hough_out_capture.sv
// Self-checking bench for hough_out_capture: sample-level reference model with
// unbounded coordinates, compared every cycle, plus hand-computed scenario checks.
module tb_hough_out_capture;
  localparam int PW   = 11;
  localparam int CW   = 3;
  localparam int CF   = 2;
  localparam int FW   = 8;
  localparam int CMAX = 7;

  logic Clk = 1'b0;
  logic nReset = 1'b0;
  logic Arm = 1'b0;
  logic [PW-1:0] PixelIn = '0;
  logic PixelEn = 1'b0, FrameIn = 1'b0, LineIn = 1'b0;
  logic [PW-1:0] PixelOut;
  logic [CW-1:0] XOut, YOut, WidthOut, HeightOut;
  logic ValidOut, FrameStart, FrameDone, LineErr, Overflow, Busy, Done;
  logic [FW-1:0] FrameCount;

  hough_out_capture #(.PIXEL_W(PW), .COORD_W(CW), .CAPTURE_FRAMES(CF), .FCNT_W(FW)) dut (
    .Clk(Clk), .nReset(nReset), .Arm(Arm), .PixelIn(PixelIn), .PixelEn(PixelEn),
    .FrameIn(FrameIn), .LineIn(LineIn), .PixelOut(PixelOut), .XOut(XOut), .YOut(YOut),
    .ValidOut(ValidOut), .FrameStart(FrameStart), .FrameDone(FrameDone),
    .WidthOut(WidthOut), .HeightOut(HeightOut), .FrameCount(FrameCount),
    .LineErr(LineErr), .Overflow(Overflow), .Busy(Busy), .Done(Done));

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  bit chk_on   = 1'b0;

  // Model: phase 0 = waiting for a frame, 1 = capturing, 2 = finished.
  int ph, cx, cy, first_len, frames;
  int m_pix, m_x, m_y, m_w, m_h, m_fc;
  bit m_valid, m_fs, m_fd, m_le, m_ov;

  function automatic int sat(int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic m_clear();
    ph = 0; cx = 0; cy = 0; first_len = -1; frames = 0;
    m_fc = 0; m_w = 0; m_h = 0; m_le = 0; m_ov = 0;
    m_valid = 0; m_fs = 0; m_fd = 0;
  endtask

  task automatic m_reset();
    m_clear();
    m_pix = 0; m_x = 0; m_y = 0;
  endtask

  task automatic m_emit(int pix, bit fs);
    if (cx > CMAX || cy > CMAX) m_ov = 1;
    m_valid = 1; m_fs = fs; m_pix = pix; m_x = sat(cx); m_y = sat(cy);
  endtask

  task automatic m_close_line();
    if (first_len < 0) first_len = sat(cx + 1);
    else if (sat(cx + 1) != first_len) m_le = 1;
  endtask

  task automatic m_start(int pix);
    cx = 0; cy = 0; first_len = -1; ph = 1;
    m_emit(pix, 1);
  endtask

  task automatic m_step(bit arm, bit en, bit fr, bit ln, int pix);
    m_valid = 0; m_fs = 0; m_fd = 0;
    if (arm) m_clear();
    else if (en) begin
      if (ph == 0) begin
        if (fr) m_start(pix);
      end else if (ph == 1) begin
        if (fr) begin
          m_close_line();
          m_w = first_len; m_h = sat(cy + 1); m_fd = 1;
          m_fc = (m_fc + 1) % 256; frames++;
          if (frames == CF) ph = 2;
          else m_start(pix);
        end else if (ln) begin
          m_close_line();
          cy++; cx = 0;
          m_emit(pix, 0);
        end else begin
          cx++;
          m_emit(pix, 0);
        end
      end
    end
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    if (ValidOut === 1'b1) n_valid++;
    cmp("ValidOut", 32'(ValidOut), 32'(m_valid));
    if (m_valid || !nReset) begin
      cmp("PixelOut", 32'(PixelOut), 32'(m_pix));
      cmp("XOut", 32'(XOut), 32'(m_x));
      cmp("YOut", 32'(YOut), 32'(m_y));
    end
    cmp("FrameStart", 32'(FrameStart), 32'(m_fs));
    cmp("FrameDone", 32'(FrameDone), 32'(m_fd));
    cmp("WidthOut", 32'(WidthOut), 32'(m_w));
    cmp("HeightOut", 32'(HeightOut), 32'(m_h));
    cmp("FrameCount", 32'(FrameCount), 32'(m_fc));
    cmp("LineErr", 32'(LineErr), 32'(m_le));
    cmp("Overflow", 32'(Overflow), 32'(m_ov));
    cmp("Busy", 32'(Busy), 32'(ph == 1));
    cmp("Done", 32'(Done), 32'(ph == 2));
  endtask

  always @(posedge Clk) begin
    #1;
    if (chk_on) compare_all();
  end

  task automatic cyc(bit arm, bit en, bit fr, bit ln);
    logic [PW-1:0] p;
    @(negedge Clk);
    p = PW'($urandom);
    Arm = arm; PixelEn = en; FrameIn = fr; LineIn = ln; PixelIn = p;
    if (nReset) m_step(arm, en, fr, ln, int'(p));
  endtask

  task automatic idle();
    cyc(0, 0, 1'($urandom), 1'($urandom));
  endtask

  task automatic settle();
    @(posedge Clk);
    #2;
  endtask

  // gap: 0 back-to-back, 1 alternate idle cycles, 2 random idle cycles
  task automatic send_frame(int w, int h, int gap, int rag_line, int rag_w, int arm_pct);
    int lw;
    bit fr, ln, arm;
    for (int l = 0; l < h; l++) begin
      lw = (l == rag_line) ? rag_w : w;
      for (int p = 0; p < lw; p++) begin
        fr  = (l == 0 && p == 0);
        ln  = (p == 0) ? (fr ? 1'($urandom) : 1'b1) : 1'b0;
        arm = ($urandom_range(0, 99) < arm_pct);
        cyc(arm, 1, fr, ln);
        if (gap == 1) idle();
        else if (gap == 2) repeat ($urandom_range(0, 2)) idle();
      end
    end
  endtask

  task automatic do_reset(int cycles);
    @(negedge Clk);
    nReset = 1'b0;
    m_reset();
    #1;
    cmp("rst_ValidOut", 32'(ValidOut), 32'd0);
    cmp("rst_Busy", 32'(Busy), 32'd0);
    cmp("rst_FrameCount", 32'(FrameCount), 32'd0);
    repeat (cycles) cyc(1'($urandom), 1, 1'($urandom), 1'($urandom));
    @(negedge Clk);
    nReset = 1'b1; Arm = 0; PixelEn = 0; FrameIn = 0; LineIn = 0;
    m_step(0, 0, 0, 0, 0);
  endtask

  initial begin
    m_reset();
    chk_on = 1'b1;
    repeat (3) @(negedge Clk);
    nReset = 1'b1;
    settle();
    cmp("reset_Width", 32'(WidthOut), 32'd0);
    cmp("reset_Done", 32'(Done), 32'd0);

    // Three back-to-back 4x3 frames, capture stops after two
    n_valid = 0;
    repeat (3) send_frame(4, 3, 0, -1, 0, 0);
    repeat (3) idle();
    settle();
    cmp("t1_valid_count", 32'(n_valid), 32'd24);
    cmp("t1_FrameCount", 32'(FrameCount), 32'd2);
    cmp("t1_Width", 32'(WidthOut), 32'd4);
    cmp("t1_Height", 32'(HeightOut), 32'd3);
    cmp("t1_Done", 32'(Done), 32'd1);
    cmp("t1_LineErr", 32'(LineErr), 32'd0);

    // Same stream with PixelEn toggling
    cyc(1, 0, 0, 0);
    n_valid = 0;
    repeat (3) send_frame(4, 3, 1, -1, 0, 0);
    repeat (3) idle();
    settle();
    cmp("t2_valid_count", 32'(n_valid), 32'd24);
    cmp("t2_FrameCount", 32'(FrameCount), 32'd2);
    cmp("t2_Done", 32'(Done), 32'd1);

    // Ragged second line
    cyc(1, 0, 0, 0);
    send_frame(4, 3, 0, 1, 5, 0);
    cyc(0, 1, 1, 1);
    settle();
    cmp("t3_LineErr", 32'(LineErr), 32'd1);
    cmp("t3_Width", 32'(WidthOut), 32'd4);
    cmp("t3_Height", 32'(HeightOut), 32'd3);
    send_frame(4, 2, 0, -1, 0, 0);
    settle();
    cmp("t3_LineErr_sticky", 32'(LineErr), 32'd1);

    // Single 10-pixel line saturates x
    cyc(1, 0, 0, 0);
    send_frame(10, 1, 0, -1, 0, 0);
    settle();
    cmp("t4_XOut_sat", 32'(XOut), 32'd7);
    cmp("t4_Overflow", 32'(Overflow), 32'd1);
    cyc(0, 1, 1, 1);
    settle();
    cmp("t4_Width", 32'(WidthOut), 32'd7);
    cmp("t4_Height", 32'(HeightOut), 32'd1);

    // Arm mid-frame, with a simultaneous sample
    cyc(1, 0, 0, 0);
    send_frame(4, 2, 0, -1, 0, 0);
    cyc(0, 1, 0, 1);
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    settle();
    cmp("t5_Busy", 32'(Busy), 32'd0);
    cmp("t5_FrameCount", 32'(FrameCount), 32'd0);
    cmp("t5_Overflow", 32'(Overflow), 32'd0);
    repeat (3) cyc(0, 1, 0, 1'($urandom));
    cyc(0, 1, 1, 1);
    settle();
    cmp("t5_FrameStart", 32'(FrameStart), 32'd1);
    cmp("t5_XOut", 32'(XOut), 32'd0);
    cmp("t5_YOut", 32'(YOut), 32'd0);

    // nReset mid-frame
    send_frame(3, 2, 0, -1, 0, 0);
    do_reset(2);
    repeat (3) cyc(0, 1, 0, 1'($urandom));
    cyc(0, 1, 1, 1);
    settle();
    cmp("t6_FrameStart", 32'(FrameStart), 32'd1);
    cmp("t6_XOut", 32'(XOut), 32'd0);

    // Randomised frames, gaps, ragged lines, stray samples and Arm pulses
    for (int it = 0; it < 40; it++) begin
      if (Done || $urandom_range(0, 5) == 0) cyc(1, 1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) cyc(0, 1, 0, 1'($urandom));
      send_frame($urandom_range(1, 10), $urandom_range(1, 10), $urandom_range(0, 2),
                 ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : -1,
                 $urandom_range(1, 10), 2);
      if (it % 13 == 12) do_reset($urandom_range(1, 3));
    end
    repeat (4) idle();
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hough_out_capture.md
# hough_out_capture

Parametrised stream capture stage at the output of the Hough accumulator. It converts a Pixel/Frame/Line stream into per-pixel (x, y, data) records with a valid strobe, and measures each frame's width and height. It counts completed frames and stops after a programmable number of frames. It also flags ragged lines and coordinate overflow, so that the bench and any later readout logic can rely on one checked stream.

## Interface
- PIXEL_W, 11, pixel data width (accumulator output width).
- COORD_W, 8, width of the x/y coordinate and width/height fields.
- CAPTURE_FRAMES, 2, number of complete frames to capture before entering DONE (≥1).
- FCNT_W, 8, width of the completed-frame counter.

- Clk  in  1  single clock; all logic rising-edge.
- nReset  in  1  asynchronous, active-low reset.
- Arm  in  1  one-cycle pulse; clears counters and flags and re-arms capture.
- PixelIn  in  PIXEL_W  pixel data.
- PixelEn  in  1  PixelIn/FrameIn/LineIn are valid this cycle.
- FrameIn  in  1  first pixel of a frame (implies LineIn).
- LineIn  in  1  first pixel of a line.
- PixelOut  out  PIXEL_W  registered pixel data.
- XOut, YOut  out  COORD_W  coordinates of PixelOut.
- ValidOut  out  1  PixelOut/XOut/YOut valid.
- FrameStart  out  1  pulse with the first ValidOut of each captured frame.
- FrameDone  out  1  pulse; WidthOut/HeightOut updated the same cycle.
- WidthOut, HeightOut  out  COORD_W  measured size of the last completed frame.
- FrameCount  out  FCNT_W  completed frames since reset/Arm.
- LineErr  out  1  sticky; a line length differed from the frame's first line.
- Overflow  out  1  sticky; a coordinate saturated.
- Busy  out  1  state is CAPTURE.
- Done  out  1  state is DONE.

## Operation
- Only samples with PixelEn=1 are acted on. FrameIn=1 with LineIn=0 is treated as FrameIn=LineIn=1.
- States: ARMED (after reset), CAPTURE, DONE.
- ARMED: ignore samples until an accepted FrameIn. On that sample:
  - x=0, y=0; emit the pixel with FrameStart.
  - Go to CAPTURE.
- CAPTURE, accepted sample with FrameIn (this closes the previous frame):
  - FrameDone; WidthOut = length of that frame's first line; HeightOut = y+1; FrameCount+1.
  - Ragged-line check on the closing line, same as for LineIn.
  - If the new FrameCount equals CAPTURE_FRAMES: go to DONE. This sample is not emitted.
  - Otherwise: x=0, y=0; emit the pixel with FrameStart.
- CAPTURE, accepted LineIn (no FrameIn):
  - The line just closed has length x+1.
  - The first line of a frame latches the reference width. A later line whose length differs sets LineErr.
  - Then x=0, y=y+1.
- CAPTURE, other accepted sample: x=x+1.
- Saturation: if x or y would exceed 2^COORD_W−1, hold at the maximum and set Overflow. A line length that saturates is compared as 2^COORD_W−1.
- DONE: ignore all samples; Done=1; WidthOut, HeightOut and FrameCount hold.
- Arm (any state):
  - Next state ARMED.
  - Clear x, y, FrameCount, WidthOut, HeightOut, LineErr and Overflow.
  - Suppress any emit that cycle; Arm wins over a simultaneous sample.
- FrameCount wraps modulo 2^FCNT_W; this can only occur if CAPTURE_FRAMES ≥ 2^FCNT_W.

## Timing
- All outputs are registered. Reset value of every output is 0; the state resets to ARMED.
- Latency: an accepted sample at edge N gives ValidOut/PixelOut/XOut/YOut at edge N+1.
- FrameStart, FrameDone and ValidOut are single-cycle pulses per accepted sample; ValidOut=0 on cycles with PixelEn=0.
- FrameDone is asserted the cycle after the closing FrameIn sample. It coincides with FrameStart of the next frame, except on the final frame.
- Done/Busy reflect the state one cycle after the transition edge.
- nReset asserted mid-frame: all state clears immediately (asynchronous). After release the block re-enters ARMED and drops samples until the next FrameIn.
- Throughput: one sample per cycle, with no back-pressure.

## Test plan
- Three back-to-back 4×3 frames, PixelEn=1, CAPTURE_FRAMES=2:
  - 24 ValidOut with x 0..3, y 0..2.
  - FrameDone twice with Width=4, Height=3.
  - FrameCount=2, Done=1; third frame not emitted; LineErr=0.
- Same stream with PixelEn toggling 1,0,1,0: identical record sequence; ValidOut only after enabled samples.
- 4-wide frame whose second line has 5 pixels: LineErr=1 at that line's closing LineIn; Width=4 reported; flag stays set until Arm.
- COORD_W=3, one line of 10 pixels: XOut saturates at 7, Overflow=1, next FrameDone Width=7.
- Arm mid-frame in CAPTURE:
  - Busy drops.
  - Counters and flags are 0.
  - Pixels before the next FrameIn are dropped; the next FrameIn emits x=0, y=0 with FrameStart.
- nReset pulsed mid-frame: all outputs 0 during reset; after release behaviour matches the Arm case.
